// File: rtl/vx_cluster_mem_arb_pkg.sv
// Shared GPU package: cluster memory arbiter select-width helper and default request entry type.
package VX_gpu_pkg;

  function automatic int unsigned cluster_arb_sel_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  localparam int unsigned CLUSTER_ARB_NUM        = 4;
  localparam int unsigned CLUSTER_ARB_ADDR_WIDTH = 26;
  localparam int unsigned CLUSTER_ARB_DATA_WIDTH = 512;
  localparam int unsigned CLUSTER_ARB_TAG_WIDTH  = 8;
  localparam int unsigned CLUSTER_ARB_SEL_BITS   = cluster_arb_sel_bits(CLUSTER_ARB_NUM);

  // Buffer entry for the default cluster configuration; tag already carries the source index.
  typedef struct packed {
    logic                                              rw;
    logic [CLUSTER_ARB_ADDR_WIDTH-1:0]                 addr;
    logic [CLUSTER_ARB_DATA_WIDTH/8-1:0]               byteen;
    logic [CLUSTER_ARB_DATA_WIDTH-1:0]                 data;
    logic [CLUSTER_ARB_TAG_WIDTH+CLUSTER_ARB_SEL_BITS-1:0] tag;
  } cluster_mem_req_t;

endpackage

// File: rtl/vx_cluster_mem_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after rr_ptr, advancing past the
// winner only when the grant is accepted.
module vx_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     requests,
  input  logic             grant_accept,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_index
);

  logic [IDX_W-1:0] rr_ptr;
  logic             found;
  int unsigned      cand;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    found        = 1'b0;
    cand         = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!found && requests[IDX_W'(cand)]) begin
        found                      = 1'b1;
        grant_onehot[IDX_W'(cand)] = 1'b1;
        grant_index                = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_accept) begin
      rr_ptr <= (32'(grant_index) == N - 1) ? '0 : grant_index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vx_elastic_buffer.sv
// Two-entry elastic (skid) buffer. in_ready depends only on occupancy, so there is no
// combinational path from out_ready back to in_ready.
module vx_elastic_buffer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic             en_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             push, pop;

  // en_q holds ready low through reset and for the first edge after release.
  assign in_ready  = en_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/vx_cluster_mem_arb.sv
// Cluster-to-L3 memory arbiter: round-robin request merge with source-index tagging and
// tag-routed responses. Optional perf counters under VX_CLUSTER_ARB_PERF_EN.
module vx_cluster_mem_arb
  import VX_gpu_pkg::*;
#(
  parameter  int unsigned NUM_CLUSTERS = 4,
  parameter  int unsigned ADDR_WIDTH   = 26,
  parameter  int unsigned DATA_WIDTH   = 512,
  parameter  int unsigned TAG_WIDTH    = 8,
  localparam int unsigned SEL_WIDTH    = cluster_arb_sel_bits(NUM_CLUSTERS)
) (
  input  logic                                      clk,
  input  logic                                      reset,

  input  logic [NUM_CLUSTERS-1:0]                   req_valid,
  input  logic [NUM_CLUSTERS-1:0]                   req_rw,
  input  logic [NUM_CLUSTERS-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CLUSTERS-1:0][DATA_WIDTH/8-1:0] req_byteen,
  input  logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_CLUSTERS-1:0][TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_CLUSTERS-1:0]                   req_ready,

  output logic                                      mem_req_valid,
  output logic                                      mem_req_rw,
  output logic [ADDR_WIDTH-1:0]                     mem_req_addr,
  output logic [DATA_WIDTH/8-1:0]                   mem_req_byteen,
  output logic [DATA_WIDTH-1:0]                     mem_req_data,
  output logic [TAG_WIDTH+SEL_WIDTH-1:0]            mem_req_tag,
  input  logic                                      mem_req_ready,

  input  logic                                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                     mem_rsp_data,
  input  logic [TAG_WIDTH+SEL_WIDTH-1:0]            mem_rsp_tag,
  output logic                                      mem_rsp_ready,

  output logic [NUM_CLUSTERS-1:0]                   rsp_valid,
  output logic [NUM_CLUSTERS-1:0][DATA_WIDTH-1:0]   rsp_data,
  output logic [NUM_CLUSTERS-1:0][TAG_WIDTH-1:0]    rsp_tag,
  input  logic [NUM_CLUSTERS-1:0]                   rsp_ready
`ifdef VX_CLUSTER_ARB_PERF_EN
  ,
  output logic [63:0]                               perf_stall_cycles,
  output logic [63:0]                               perf_req_count
`endif
);

  localparam int unsigned IDX_W  = (NUM_CLUSTERS > 1) ? SEL_WIDTH : 1;
  localparam int unsigned MTAG_W = TAG_WIDTH + SEL_WIDTH;

  typedef struct packed {
    logic                    rw;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] byteen;
    logic [DATA_WIDTH-1:0]   data;
    logic [MTAG_W-1:0]       tag;
  } req_entry_t;

  // ---------------- request path ----------------
  logic [NUM_CLUSTERS-1:0] grant_onehot;
  logic [IDX_W-1:0]        grant_index;
  logic                    req_buf_can_accept;
  logic                    any_valid;
  logic                    req_accept;
  logic [MTAG_W-1:0]       req_in_tag;
  req_entry_t              req_in, req_out;

  assign any_valid  = |req_valid;
  assign req_accept = any_valid & req_buf_can_accept;
  assign req_ready  = grant_onehot & {NUM_CLUSTERS{req_buf_can_accept}};

  vx_rr_arbiter #(
    .N (NUM_CLUSTERS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (req_valid),
    .grant_accept (req_accept),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index)
  );

  if (SEL_WIDTH > 0) begin : g_tag_sel
    assign req_in_tag = {req_tag[grant_index], grant_index};
  end else begin : g_tag_pass
    assign req_in_tag = req_tag[grant_index];
  end

  always_comb begin
    req_in.rw     = req_rw[grant_index];
    req_in.addr   = req_addr[grant_index];
    req_in.byteen = req_byteen[grant_index];
    req_in.data   = req_data[grant_index];
    req_in.tag    = req_in_tag;
  end

  vx_elastic_buffer #(
    .WIDTH ($bits(req_entry_t))
  ) u_req_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (any_valid),
    .in_ready  (req_buf_can_accept),
    .in_data   (req_in),
    .out_valid (mem_req_valid),
    .out_ready (mem_req_ready),
    .out_data  (req_out)
  );

  assign mem_req_rw     = req_out.rw;
  assign mem_req_addr   = req_out.addr;
  assign mem_req_byteen = req_out.byteen;
  assign mem_req_data   = req_out.data;
  assign mem_req_tag    = req_out.tag;

  // ---------------- response path ----------------
  logic                  rsp_head_valid;
  logic                  rsp_head_ready;
  logic [DATA_WIDTH-1:0] rsp_head_data;
  logic [MTAG_W-1:0]     rsp_head_tag;
  logic [IDX_W-1:0]      rsp_sel;
  logic [TAG_WIDTH-1:0]  rsp_out_tag;

  vx_elastic_buffer #(
    .WIDTH (DATA_WIDTH + MTAG_W)
  ) u_rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_rsp_valid),
    .in_ready  (mem_rsp_ready),
    .in_data   ({mem_rsp_data, mem_rsp_tag}),
    .out_valid (rsp_head_valid),
    .out_ready (rsp_head_ready),
    .out_data  ({rsp_head_data, rsp_head_tag})
  );

  if (SEL_WIDTH > 0) begin : g_rsp_sel
    assign rsp_sel     = rsp_head_tag[SEL_WIDTH-1:0];
    assign rsp_out_tag = rsp_head_tag[MTAG_W-1:SEL_WIDTH];
  end else begin : g_rsp_pass
    assign rsp_sel     = '0;
    assign rsp_out_tag = rsp_head_tag;
  end

  // A select beyond the last cluster has no consumer; drop it rather than wedge the path.
  always_comb begin
    rsp_valid      = '0;
    rsp_head_ready = 1'b1;
    if (32'(rsp_sel) < NUM_CLUSTERS) begin
      rsp_valid[rsp_sel] = rsp_head_valid;
      rsp_head_ready     = rsp_ready[rsp_sel];
    end
  end

  assign rsp_data = {NUM_CLUSTERS{rsp_head_data}};
  assign rsp_tag  = {NUM_CLUSTERS{rsp_out_tag}};

`ifdef VX_CLUSTER_ARB_PERF_EN
  logic [63:0] stall_cycles_q;
  logic [63:0] req_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 64'd0;
      req_count_q    <= 64'd0;
    end else begin
      if (any_valid && !req_accept) stall_cycles_q <= stall_cycles_q + 64'd1;
      if (req_accept)               req_count_q    <= req_count_q + 64'd1;
    end
  end

  assign perf_stall_cycles = stall_cycles_q;
  assign perf_req_count    = req_count_q;
`endif

endmodule

// File: tb/tb_vx_cluster_mem_arb.sv
// Directed bench for vx_cluster_mem_arb: table-driven arbitration/backpressure vectors plus
// hand sequences for single request, response routing, reset mid-traffic and perf counters.
module tb_vx_cluster_mem_arb;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int SW = 2;
  localparam int BW = DW / 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [N-1:0]              req_valid, req_rw, req_ready;
  logic [N-1:0][AW-1:0]      req_addr;
  logic [N-1:0][BW-1:0]      req_byteen;
  logic [N-1:0][DW-1:0]      req_data;
  logic [N-1:0][TW-1:0]      req_tag;
  logic                      mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0]             mem_req_addr;
  logic [BW-1:0]             mem_req_byteen;
  logic [DW-1:0]             mem_req_data;
  logic [TW+SW-1:0]          mem_req_tag;
  logic                      mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]             mem_rsp_data;
  logic [TW+SW-1:0]          mem_rsp_tag;
  logic [N-1:0]              rsp_valid, rsp_ready;
  logic [N-1:0][DW-1:0]      rsp_data;
  logic [N-1:0][TW-1:0]      rsp_tag;
`ifdef VX_CLUSTER_ARB_PERF_EN
  logic [63:0]               perf_stall_cycles, perf_req_count;
  logic [63:0]               stall0, cnt0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_cluster_mem_arb dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_byteen     (req_byteen),
    .req_data       (req_data),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_ready      (rsp_ready)
`ifdef VX_CLUSTER_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_req_count    (perf_req_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_tags(input logic [7:0] t);
    for (int i = 0; i < N; i++) begin
      req_tag[i]    = t + 8'(i);
      req_addr[i]   = AW'(32'h100 * (i + 1));
      req_data[i]   = {16{32'hA000 + 32'(i)}};
      req_byteen[i] = '1;
      req_rw[i]     = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic        mrr;
    logic [7:0]  tbase;
    logic [3:0]  exp_ready;
    logic        exp_mvalid;
    logic [9:0]  exp_mtag;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // Arbitration, fairness and backpressure; tag = {tbase+i, i}.
    vecs[0]  = '{4'b1111, 1'b1, 8'h10, 4'b0001, 1'b0, 10'h000};
    vecs[1]  = '{4'b1111, 1'b1, 8'h10, 4'b0010, 1'b1, 10'h040};
    vecs[2]  = '{4'b1111, 1'b1, 8'h10, 4'b0100, 1'b1, 10'h045};
    vecs[3]  = '{4'b1111, 1'b1, 8'h10, 4'b1000, 1'b1, 10'h04A};
    vecs[4]  = '{4'b1111, 1'b1, 8'h10, 4'b0001, 1'b1, 10'h04F};
    vecs[5]  = '{4'b0101, 1'b1, 8'h10, 4'b0100, 1'b1, 10'h040};
    vecs[6]  = '{4'b0101, 1'b1, 8'h10, 4'b0001, 1'b1, 10'h04A};
    vecs[7]  = '{4'b0000, 1'b1, 8'h10, 4'b0000, 1'b1, 10'h040};
    vecs[8]  = '{4'b0000, 1'b1, 8'h10, 4'b0000, 1'b0, 10'h000};
    vecs[9]  = '{4'b1000, 1'b0, 8'h20, 4'b1000, 1'b0, 10'h000};
    vecs[10] = '{4'b1000, 1'b0, 8'h30, 4'b1000, 1'b1, 10'h08F};
    vecs[11] = '{4'b1000, 1'b0, 8'h30, 4'b0000, 1'b1, 10'h08F};
    vecs[12] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 10'h08F};
    vecs[13] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b1, 10'h0CF};
    vecs[14] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0, 10'h000};

    reset         = 1'b0;
    req_valid     = 4'b1111;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    rsp_ready     = '0;
    set_tags(8'h00);

    // Reset state
    #1;
    chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset req_ready",     64'(req_ready),     64'd0);
    chk("reset rsp_valid",     64'(rsp_valid),     64'd0);
    chk("reset mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("req_ready before first edge", 64'(req_ready), 64'd0);

    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      req_valid     = vecs[k].valid;
      mem_req_ready = vecs[k].mrr;
      set_tags(vecs[k].tbase);
      #1;
      chk($sformatf("vec%0d req_ready", k), 64'(req_ready), 64'(vecs[k].exp_ready));
      chk($sformatf("vec%0d mem_req_valid", k), 64'(mem_req_valid), 64'(vecs[k].exp_mvalid));
      if (vecs[k].exp_mvalid)
        chk($sformatf("vec%0d mem_req_tag", k), 64'(mem_req_tag), 64'(vecs[k].exp_mtag));
    end

    // Single request from cluster 2
    @(negedge clk);
    set_tags(8'h00);
    req_tag[2]    = 8'h5A;
    req_addr[2]   = 26'h100;
    req_valid     = 4'b0100;
    mem_req_ready = 1'b0;
    #1;
    chk("single req_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("single mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("single mem_req_tag",   64'(mem_req_tag),   64'h16A);
    chk("single mem_req_addr",  64'(mem_req_addr),  64'h100);
    chk("single mem_req_rw",    64'(mem_req_rw),    64'd0);
    chk("single mem_req_data",  mem_req_data[63:0], {2{32'hA002}});
    chk("single rr_ptr",        64'(dut.u_arb.rr_ptr), 64'd3);
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("single drained", 64'(mem_req_valid), 64'd0);

    // Response routing and head-of-line blocking
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 10'h0CD;
    mem_rsp_data  = {16{32'h1111_0001}};
    rsp_ready     = 4'b0000;
    #1;
    chk("rsp0 mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    chk("rsp0 rsp_valid",     64'(rsp_valid),     64'd0);
    @(negedge clk);
    mem_rsp_tag  = 10'h113;
    mem_rsp_data = {16{32'h2222_0003}};
    #1;
    chk("rsp1 rsp_valid",     64'(rsp_valid),     64'h2);
    chk("rsp1 mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    chk("rsp2 rsp_valid",     64'(rsp_valid),     64'h2);
    chk("rsp2 mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    chk("rsp2 rsp_tag1",      64'(rsp_tag[1]),    64'h33);
    chk("rsp2 rsp_data1",     rsp_data[1][63:0],  {2{32'h1111_0001}});
    @(negedge clk);
    rsp_ready = 4'b1000;
    #1;
    chk("rsp3 hol rsp_valid", 64'(rsp_valid), 64'h2);
    @(negedge clk);
    rsp_ready = 4'b0010;
    #1;
    chk("rsp4 rsp_valid", 64'(rsp_valid), 64'h2);
    @(negedge clk);
    rsp_ready = 4'b1000;
    #1;
    chk("rsp5 rsp_valid",     64'(rsp_valid),     64'h8);
    chk("rsp5 rsp_tag3",      64'(rsp_tag[3]),    64'h44);
    chk("rsp5 rsp_data3",     rsp_data[3][63:0],  {2{32'h2222_0003}});
    chk("rsp5 mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    chk("rsp6 empty", 64'(rsp_valid), 64'd0);

    // Reset with both buffers full
    @(negedge clk);
    set_tags(8'h60);
    req_valid     = 4'b1111;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 10'h0CD;
    repeat (2) @(negedge clk);
    #1;
    chk("full mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("full req_ready",     64'(req_ready),     64'd0);
    chk("full rsp_valid",     64'(rsp_valid),     64'h2);
    chk("full mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("async mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("async req_ready",     64'(req_ready),     64'd0);
    chk("async rsp_valid",     64'(rsp_valid),     64'd0);
    chk("async mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    reset         = 1'b1;
    #1;
    chk("post-reset req_ready gated", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("post-reset grant idx0", 64'(req_ready),     64'h1);
    chk("post-reset mem empty",  64'(mem_req_valid), 64'd0);
    @(negedge clk);
    req_valid     = 4'b0000;
    mem_req_ready = 1'b1;
    #1;
    chk("post-reset mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("post-reset mem_req_tag",   64'(mem_req_tag),   64'h180);

`ifdef VX_CLUSTER_ARB_PERF_EN
    @(negedge clk);
    stall0        = perf_stall_cycles;
    cnt0          = perf_req_count;
    req_valid     = 4'b1111;
    mem_req_ready = 1'b0;
    repeat (10) @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("perf stall cycles", perf_stall_cycles - stall0, 64'd8);
    chk("perf req count",    perf_req_count - cnt0,      64'd2);
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
